// File: rtl/bcd_stopwatch_scan.sv
// -----------------------------------------------------------------------------
// bcd_stopwatch_scan
//
// Stopwatch core: an N-digit BCD (or binary) time counter controlled by
// start/stop/lap/clear command pulses. It has a timed lap-hold display and an
// N-digit multiplexed 7-segment scan driver. It sits between the debounced
// button pulses and the segment/digit pins at board top level.
//
// Parameters
//   DIGITS    number of 4-bit digits counted and scanned (1..8)
//   TICK_DIV  CLK cycles per count increment (>=2)
//   SCAN_DIV  CLK cycles each digit is driven (>=2)
//   LAP_HOLD  ticks the lap value stays on display after a lap command (1..255)
//   BCD       1: decimal digits 0-9, 0: plain binary (hex digits)
//
// Ports
//   CLK        in   system clock, all logic on the rising edge
//   RST_N      in   asynchronous active-low reset
//   start      in   1-cycle pulse: begin/resume counting
//   stop       in   1-cycle pulse: halt counting
//   lap        in   1-cycle pulse: capture count, show it for LAP_HOLD ticks
//   clear      in   1-cycle pulse: zero count, stop, cancel lap hold
//   seg        out  segments {g,f,e,d,c,b,a}, active-low
//   dp         out  decimal point, active-low, lit on digit index 2 only
//   dig_sel    out  digit enables, one-hot active-low, bit 0 = least significant
//   count      out  live counter value (not the displayed value)
//   running    out  counting enabled
//   lap_active out  lap value currently displayed
//   overflow   out  sticky: counter wrapped from maximum to zero
// -----------------------------------------------------------------------------
module bcd_stopwatch_scan #(
   parameter int DIGITS   = 4,
   parameter int TICK_DIV = 12000,
   parameter int SCAN_DIV = 1024,
   parameter int LAP_HOLD = 200,
   parameter int BCD      = 1
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  lap,
   input  logic                  clear,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [DIGITS-1:0]     dig_sel,
   output logic [4*DIGITS-1:0]   count,
   output logic                  running,
   output logic                  lap_active,
   output logic                  overflow
);

   localparam int CW  = 4 * DIGITS;
   localparam int TDW = $clog2(TICK_DIV);
   localparam int SDW = $clog2(SCAN_DIV);
   localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [TDW-1:0]    TICK_LAST = TDW'(TICK_DIV - 1);
   localparam logic [SDW-1:0]    SCAN_LAST = SDW'(SCAN_DIV - 1);
   localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
   localparam logic [7:0]        HOLD_LOAD = 8'(LAP_HOLD);
   localparam logic [DIGITS-1:0] SEL_LSB   = DIGITS'(1);

   // Counter increment: per-digit decimal carry, or plain binary +1.
   // Any digit >= 9 rolls to zero so an out-of-range code cannot stick.
   function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] v);
      logic [CW-1:0] r;
      logic          carry;
      r     = v;
      carry = 1'b1;
      if (BCD != 0) begin
         for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
               if (v[4*i +: 4] >= 4'd9) begin
                  r[4*i +: 4] = 4'd0;
               end else begin
                  r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                  carry       = 1'b0;
               end
            end
         end
      end else begin
         r = v + CW'(1);
      end
      return r;
   endfunction

   // Hex digit to active-low {g,f,e,d,c,b,a}. In decimal mode A-F blank.
   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] on;
      case (d)
         4'h0: on = 7'h3F;
         4'h1: on = 7'h06;
         4'h2: on = 7'h5B;
         4'h3: on = 7'h4F;
         4'h4: on = 7'h66;
         4'h5: on = 7'h6D;
         4'h6: on = 7'h7D;
         4'h7: on = 7'h07;
         4'h8: on = 7'h7F;
         4'h9: on = 7'h6F;
         4'hA: on = 7'h77;
         4'hB: on = 7'h7C;
         4'hC: on = 7'h39;
         4'hD: on = 7'h5E;
         4'hE: on = 7'h79;
         default: on = 7'h71;
      endcase
      if ((BCD != 0) && (d > 4'd9)) begin
         on = 7'h00;
      end
      return ~on;
   endfunction

   logic [TDW-1:0] tick_div;
   logic           tick;
   logic [CW-1:0]  count_q;
   logic [CW-1:0]  count_nxt;
   logic           running_q;
   logic           overflow_q;
   logic [CW-1:0]  lap_reg;
   logic [7:0]     lap_timer;
   logic [SDW-1:0] scan_div;
   logic [IW-1:0]  dig_idx;
   logic [CW-1:0]  disp;
   logic [CW-1:0]  disp_sh;
   logic [6:0]     seg_p1;
   logic           dp_p1;
   logic [DIGITS-1:0] dig_sel_p1;

   assign tick      = (tick_div == TICK_LAST);
   assign count_nxt = cnt_inc(count_q);

   // Tick divider; clear restarts the count interval, start does not.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         tick_div <= '0;
      end else if (clear || tick) begin
         tick_div <= '0;
      end else begin
         tick_div <= tick_div + TDW'(1);
      end
   end

   // Run control: clear > stop > start.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         running_q <= 1'b0;
      end else if (clear || stop) begin
         running_q <= 1'b0;
      end else if (start) begin
         running_q <= 1'b1;
      end
   end

   // Time counter and sticky wrap flag; a tick coinciding with clear is lost.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else if (clear) begin
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else if (tick && running_q) begin
         count_q <= count_nxt;
         if (count_nxt == '0) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // Lap capture and hold timer. The register survives clear, only the hold
   // is cancelled. The timer runs on ticks whether or not counting is enabled.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         lap_reg   <= '0;
         lap_timer <= '0;
      end else if (clear) begin
         lap_timer <= '0;
      end else if (lap) begin
         lap_reg   <= count_q;
         lap_timer <= HOLD_LOAD;
      end else if (tick && (lap_timer != 8'd0)) begin
         lap_timer <= lap_timer - 8'd1;
      end
   end

   // Scan divider and digit index.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         scan_div <= '0;
         dig_idx  <= '0;
      end else if (scan_div == SCAN_LAST) begin
         scan_div <= '0;
         dig_idx  <= (dig_idx == IDX_LAST) ? '0 : dig_idx + IW'(1);
      end else begin
         scan_div <= scan_div + SDW'(1);
      end
   end

   assign disp    = (lap_timer != 8'd0) ? lap_reg : count_q;
   assign disp_sh = disp >> {dig_idx, 2'b00};

   // ---- display output register stage (p1) ----
   // seg, dp and dig_sel all come from the same index value so they switch
   // on the same edge and no neighbouring digit ghosts.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         seg_p1     <= 7'h7F;
         dp_p1      <= 1'b1;
         dig_sel_p1 <= '1;
      end else begin
         seg_p1     <= seg_decode(disp_sh[3:0]);
         dp_p1      <= (32'(dig_idx) != 32'd2);
         dig_sel_p1 <= ~(SEL_LSB << dig_idx);
      end
   end

   assign seg        = seg_p1;
   assign dp         = dp_p1;
   assign dig_sel    = dig_sel_p1;
   assign count      = count_q;
   assign running    = running_q;
   assign lap_active = (lap_timer != 8'd0);
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_bcd_stopwatch_scan.sv
// -----------------------------------------------------------------------------
// tb_bcd_stopwatch_scan
//
// Directed bench for bcd_stopwatch_scan. Decimal instance: DIGITS=4,
// TICK_DIV=4, SCAN_DIV=3, LAP_HOLD=3. A second, binary instance (DIGITS=3,
// TICK_DIV=2) covers hex glyphs and the all-ones to zero wrap within a short
// run. Expected values are worked out from the edge count since the reset
// release: with the divider starting at zero, a tick lands on every 4th edge
// (binary instance: every 2nd), and the scan index moves every 3rd edge.
// -----------------------------------------------------------------------------
module tb_bcd_stopwatch_scan;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic        RST_N;
   logic        start, stop, lap, clear;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  dig_sel;
   logic [15:0] count;
   logic        running, lap_active, overflow;

   logic        h_start, h_stop, h_lap, h_clear;
   logic [6:0]  h_seg;
   logic        h_dp;
   logic [2:0]  h_dig_sel;
   logic [11:0] h_count;
   logic        h_running, h_lap_active, h_overflow;

   int errors = 0;
   int checks = 0;

   logic [11:0] scan_vec [0:11];

   bcd_stopwatch_scan #(
      .DIGITS(4), .TICK_DIV(4), .SCAN_DIV(3), .LAP_HOLD(3), .BCD(1)
   ) u_dut (
      .CLK(CLK), .RST_N(RST_N),
      .start(start), .stop(stop), .lap(lap), .clear(clear),
      .seg(seg), .dp(dp), .dig_sel(dig_sel), .count(count),
      .running(running), .lap_active(lap_active), .overflow(overflow)
   );

   bcd_stopwatch_scan #(
      .DIGITS(3), .TICK_DIV(2), .SCAN_DIV(3), .LAP_HOLD(3), .BCD(0)
   ) u_hex (
      .CLK(CLK), .RST_N(RST_N),
      .start(h_start), .stop(h_stop), .lap(h_lap), .clear(h_clear),
      .seg(h_seg), .dp(h_dp), .dig_sel(h_dig_sel), .count(h_count),
      .running(h_running), .lap_active(h_lap_active), .overflow(h_overflow)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges, then settle 1 time unit past the edge.
   task automatic step(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_count"},   32'(count),      32'h0);
      check({tag, "_running"}, 32'(running),    32'h0);
      check({tag, "_ovf"},     32'(overflow),   32'h0);
      check({tag, "_lap"},     32'(lap_active), 32'h0);
      check({tag, "_seg"},     32'(seg),        32'h7F);
      check({tag, "_dp"},      32'(dp),         32'h1);
      check({tag, "_digsel"},  32'(dig_sel),    32'hF);
   endtask

   initial begin
      // {dig_sel, dp, seg} after edges 122..133 (live count 30..33)
      scan_vec = '{
         {4'b1110, 1'b1, 7'h40}, {4'b1110, 1'b1, 7'h40},
         {4'b1101, 1'b1, 7'h30}, {4'b1101, 1'b1, 7'h30}, {4'b1101, 1'b1, 7'h30},
         {4'b1011, 1'b0, 7'h40}, {4'b1011, 1'b0, 7'h40}, {4'b1011, 1'b0, 7'h40},
         {4'b0111, 1'b1, 7'h40}, {4'b0111, 1'b1, 7'h40}, {4'b0111, 1'b1, 7'h40},
         {4'b1110, 1'b1, 7'h30}
      };

      RST_N = 1'b0;
      start = 1'b0; stop = 1'b0; lap = 1'b0; clear = 1'b0;
      h_start = 1'b0; h_stop = 1'b0; h_lap = 1'b0; h_clear = 1'b0;

      step(3);
      check_reset("rst");

      // Release reset with a start pulse; the next edge is edge 1.
      RST_N = 1'b1;
      start = 1'b1;
      step(1);
      start = 1'b0;
      check("start_running", 32'(running), 32'h1);

      step(39);                                   // edge 40: 10 ticks
      check("run40_count", 32'(count),    32'h0010);
      check("run40_run",   32'(running),  32'h1);
      check("run40_ovf",   32'(overflow), 32'h0);

      // Lap hold at 0025
      step(61);                                   // edge 101
      check("pre_lap_count", 32'(count), 32'h0025);
      lap = 1'b1;
      step(1);                                    // edge 102
      lap = 1'b0;
      check("lap_active_on", 32'(lap_active), 32'h1);
      check("lap_count",     32'(count),      32'h0025);
      step(7);                                    // edge 109: digit 0 of held value
      check("hold_digsel", 32'(dig_sel), 32'hE);
      check("hold_seg5",   32'(seg),     32'h12);
      check("hold_live",   32'(count),   32'h0027);
      step(2);                                    // edge 111: last held cycle
      check("hold_end_lap",  32'(lap_active), 32'h1);
      check("hold_end_seg5", 32'(seg),        32'h12);
      step(1);                                    // edge 112: third tick ends hold
      check("hold_off_lap",   32'(lap_active), 32'h0);
      check("hold_off_count", 32'(count),      32'h0028);
      step(9);                                    // edge 121: digit 0 of live 30
      check("live_digsel", 32'(dig_sel), 32'hE);
      check("live_seg0",   32'(seg),     32'h40);

      // Scan sequence, 3 cycles per digit
      for (int i = 0; i < 12; i++) begin
         step(1);
         check($sformatf("scan%0d_sel", i), 32'(dig_sel), 32'(scan_vec[i][11:8]));
         check($sformatf("scan%0d_dp", i),  32'(dp),      32'(scan_vec[i][7]));
         check($sformatf("scan%0d_seg", i), 32'(seg),     32'(scan_vec[i][6:0]));
      end

      // start and stop together while running
      start = 1'b1; stop = 1'b1;
      step(1);                                    // edge 134
      start = 1'b0; stop = 1'b0;
      check("startstop_run", 32'(running), 32'h0);
      step(4);                                    // edge 138, tick at 136 ignored
      check("stopped_count", 32'(count), 32'h0033);
      start = 1'b1;
      step(1);                                    // edge 139
      start = 1'b0;
      check("resume_run", 32'(running), 32'h1);
      step(1);                                    // edge 140: tick
      check("resume_count", 32'(count), 32'h0034);

      // clear + lap coincide with a tick at edge 144
      step(3);
      clear = 1'b1; lap = 1'b1;
      step(1);
      clear = 1'b0; lap = 1'b0;
      check("clr_count", 32'(count),      32'h0);
      check("clr_run",   32'(running),    32'h0);
      check("clr_lap",   32'(lap_active), 32'h0);
      check("clr_ovf",   32'(overflow),   32'h0);

      // Run to 9998, then wrap; divider restarted by clear.
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(39991);                                // 9998 ticks
      check("pre9998",     32'(count),    32'h9998);
      check("pre9998_ovf", 32'(overflow), 32'h0);
      step(4);
      check("at9999", 32'(count), 32'h9999);
      step(4);
      check("wrap_count", 32'(count),    32'h0000);
      check("wrap_ovf",   32'(overflow), 32'h1);
      check("wrap_run",   32'(running),  32'h1);
      clear = 1'b1;
      step(1);
      clear = 1'b0;
      check("ovf_cleared",   32'(overflow), 32'h0);
      check("ovf_clr_count", 32'(count),    32'h0);

      // Asynchronous reset mid-count and mid-hold
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(8);
      check("mid_count", 32'(count), 32'h0002);
      lap = 1'b1;
      step(1);
      lap = 1'b0;
      check("mid_lap", 32'(lap_active), 32'h1);
      #2;
      RST_N = 1'b0;
      #1;
      check_reset("async");

      // Binary instance: release reset with start, tick every 2nd edge.
      #2;
      RST_N = 1'b1;
      h_start = 1'b1;
      step(1);
      h_start = 1'b0;
      check("hex_run", 32'(h_running), 32'h1);
      step(19);                                   // edge 20: 10 ticks
      check("hex_count_A", 32'(h_count), 32'h00A);
      step(1);                                    // edge 21: digit 0 shows A
      check("hex_digsel", 32'(h_dig_sel), 32'h6);
      check("hex_segA",   32'(h_seg),     32'h08);
      check("hex_dp",     32'(h_dp),      32'h1);
      step(8169);                                 // edge 8190
      check("hex_fff",     32'(h_count),    32'hFFF);
      check("hex_fff_ovf", 32'(h_overflow), 32'h0);
      step(2);
      check("hex_wrap",     32'(h_count),    32'h000);
      check("hex_wrap_ovf", 32'(h_overflow), 32'h1);
      check("dec_idle", 32'(count), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
